// File: rtl/bcd_display_mux.sv
// Two-digit, time-multiplexed seven-segment driver for a packed BCD count.
// The display alternates between the units and tens digits every REFRESH_DIV
// cycles. The count is sampled once per frame, on entry to the units slot, so
// both digits of a frame always come from the same value. A rising edge on TC
// lights the shared decimal point for BLINK_SLOTS digit slots.
//
// Ports:
//   clk      - system clock, rising edge
//   resetn   - asynchronous active-low reset
//   count    - packed BCD value, [7:4] tens, [3:0] units
//   TC       - terminal-count level from the counter
//   blank_lz - blank the tens digit when it is zero
//   seg      - segments {a,b,c,d,e,f,g}, active-low
//   an       - digit enables, [0] units, [1] tens, active-low
//   dp       - decimal point, active-low
//   err      - snapshot holds a non-BCD nibble
module bcd_display_mux #(
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned BLINK_SLOTS = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] count,
  input  logic       TC,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp,
  output logic       err
);

  localparam int unsigned PreW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(REFRESH_DIV - 1);
  localparam logic [7:0] BlinkLoad = 8'(BLINK_SLOTS);

  logic [PreW-1:0] pre_q, pre_d;
  logic            sel_q, sel_d;  // 1 = tens slot
  logic [7:0]      snap_q, snap_d;
  logic            tc_q;
  logic [7:0]      bc_q, bc_d;
  logic [6:0]      seg_q, seg_d;
  logic [1:0]      an_q, an_d;
  logic            dp_q, dp_d;
  logic            err_q, err_d;

  logic       strobe;
  logic       tc_rise;
  logic       blank;
  logic [3:0] digit;
  logic [6:0] glyph;  // active-high {a..g}

  always_comb begin
    strobe  = (pre_q == PreMax);
    pre_d   = strobe ? '0 : pre_q + 1'b1;
    sel_d   = strobe ? ~sel_q : sel_q;
    // Sample only when leaving the tens slot, i.e. at the start of a frame.
    snap_d  = (strobe && sel_q) ? count : snap_q;

    tc_rise = TC & ~tc_q;
    bc_d    = bc_q;
    if (tc_rise) begin
      bc_d = BlinkLoad;
    end else if (strobe && (bc_q != 8'd0)) begin
      bc_d = bc_q - 8'd1;
    end
  end

  always_comb begin
    digit = sel_q ? snap_q[7:4] : snap_q[3:0];
    case (digit)
      4'd0:    glyph = 7'b1111110;
      4'd1:    glyph = 7'b0110000;
      4'd2:    glyph = 7'b1101101;
      4'd3:    glyph = 7'b1111001;
      4'd4:    glyph = 7'b0110011;
      4'd5:    glyph = 7'b1011011;
      4'd6:    glyph = 7'b1011111;
      4'd7:    glyph = 7'b1110000;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1111011;
      default: glyph = 7'b0000001;  // dash for non-BCD nibbles
    endcase

    blank = sel_q & blank_lz & (snap_q[7:4] == 4'd0);
    seg_d = blank ? 7'h7F : ~glyph;
    an_d  = blank ? 2'b11 : (sel_q ? 2'b01 : 2'b10);
    dp_d  = (bc_q == 8'd0);
    err_d = (snap_q[7:4] > 4'd9) | (snap_q[3:0] > 4'd9);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_q  <= '0;
      sel_q  <= 1'b1;
      snap_q <= 8'h00;
      tc_q   <= 1'b0;
      bc_q   <= 8'd0;
      seg_q  <= 7'h7F;
      an_q   <= 2'b11;
      dp_q   <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      sel_q  <= sel_d;
      snap_q <= snap_d;
      tc_q   <= TC;
      bc_q   <= bc_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      dp_q   <= dp_d;
      err_q  <= err_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;
  assign err = err_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
module tb_bcd_display_mux;

  localparam int R = 4;
  localparam int B = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [7:0] count = 8'h00;
  logic       TC = 1'b0;
  logic       blank_lz = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_display_mux #(
    .REFRESH_DIV(R),
    .BLINK_SLOTS(B)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .count   (count),
    .TC      (TC),
    .blank_lz(blank_lz),
    .seg     (seg),
    .an      (an),
    .dp      (dp),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, got, want);
    end
  endtask

  // Active-high {a..g} glyph of a nibble.
  function automatic logic [6:0] glyph_of(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000001;
    endcase
  endfunction

  // Behavioural model: slot position derived from the number of edges since
  // reset release, expected outputs formed from the state before each edge.
  logic [6:0] exp_seg = 7'h7F;
  logic [1:0] exp_an  = 2'b11;
  logic       exp_dp  = 1'b1;
  logic       exp_err = 1'b0;

  initial begin
    int k;
    int m_snap;
    int m_left;
    bit m_tc;
    k = 0; m_snap = 0; m_left = 0; m_tc = 0;
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        k = 0; m_snap = 0; m_left = 0; m_tc = 0;
        exp_seg = 7'h7F; exp_an = 2'b11; exp_dp = 1'b1; exp_err = 1'b0;
      end else begin
        bit tens_slot;
        bit strb;
        int tens;
        int units;
        tens_slot = ((k / R) % 2) == 0;
        strb      = (k % R) == (R - 1);
        tens      = m_snap / 16;
        units     = m_snap % 16;
        if (tens_slot && blank_lz && tens == 0) begin
          exp_an  = 2'b11;
          exp_seg = 7'h7F;
        end else begin
          exp_an  = tens_slot ? 2'b01 : 2'b10;
          exp_seg = ~glyph_of(tens_slot ? tens : units);
        end
        exp_dp  = (m_left == 0);
        exp_err = (tens > 9) || (units > 9);
        if (strb && tens_slot) m_snap = int'(count);
        if (TC && !m_tc) m_left = B;
        else if (strb && m_left > 0) m_left = m_left - 1;
        m_tc = TC;
        k++;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("model_seg", {1'b0, seg}, {1'b0, exp_seg});
      chk("model_an", {6'd0, an}, {6'd0, exp_an});
      chk("model_dp", {7'd0, dp}, {7'd0, exp_dp});
      chk("model_err", {7'd0, err}, {7'd0, exp_err});
    end
  end

  task automatic wait_an(input logic [1:0] want, input string name);
    int i;
    i = 0;
    while (an !== want && i < 4 * R) begin
      @(negedge clk);
      i++;
    end
    chk(name, {6'd0, an}, {6'd0, want});
  endtask

  initial begin
    int n;
    int falls;
    logic prev_dp;

    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_an", {6'd0, an}, 8'h03);
    chk("rst_dp", {7'd0, dp}, 8'h01);
    chk("rst_err", {7'd0, err}, 8'h00);
    resetn = 1'b1;
    @(negedge clk);
    chk("first_tens_an", {6'd0, an}, 8'h01);
    chk("first_tens_seg", {1'b0, seg}, 8'h01);

    // Normal display of 48.
    count = 8'h48;
    wait_an(2'b10, "sync_units0");
    wait_an(2'b01, "sync_tens0");
    wait_an(2'b10, "norm_units_an");
    chk("norm_units_seg", {1'b0, seg}, 8'h00);
    n = 0;
    while (an === 2'b10 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("units_slot_len", 8'(n), 8'(R));
    chk("norm_tens_an", {6'd0, an}, 8'h01);
    chk("norm_tens_seg", {1'b0, seg}, 8'h4C);

    // Asynchronous reset mid-slot.
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_seg", {1'b0, seg}, 8'h7F);
    chk("async_rst_an", {6'd0, an}, 8'h03);
    chk("async_rst_dp", {7'd0, dp}, 8'h01);
    chk("async_rst_err", {7'd0, err}, 8'h00);
    repeat (3) @(negedge clk);
    chk("held_rst_an", {6'd0, an}, 8'h03);

    // Leading-zero blanking of 07.
    count = 8'h07;
    blank_lz = 1'b1;
    resetn = 1'b1;
    @(negedge clk);
    chk("lz_rst_tens_an", {6'd0, an}, 8'h03);
    wait_an(2'b10, "lz_units_an");
    chk("lz_units_seg", {1'b0, seg}, 8'h0F);
    repeat (R) @(negedge clk);
    chk("lz_tens_an", {6'd0, an}, 8'h03);
    chk("lz_tens_seg", {1'b0, seg}, 8'h7F);
    blank_lz = 1'b0;
    @(negedge clk);
    chk("nolz_tens_an", {6'd0, an}, 8'h01);
    chk("nolz_tens_seg", {1'b0, seg}, 8'h01);

    // Snapshot holds across a count change inside the frame.
    count = 8'h19;
    wait_an(2'b10, "snap_units_an");
    chk("snap_units_seg", {1'b0, seg}, 8'h04);
    count = 8'h20;
    wait_an(2'b01, "snap_tens_an");
    chk("snap_tens_seg", {1'b0, seg}, 8'h4F);
    wait_an(2'b10, "next_units_an");
    chk("next_units_seg", {1'b0, seg}, 8'h01);
    wait_an(2'b01, "next_tens_an");
    chk("next_tens_seg", {1'b0, seg}, 8'h12);

    // Invalid digit.
    count = 8'h3C;
    wait_an(2'b10, "inv_units_an");
    chk("inv_units_seg", {1'b0, seg}, 8'h7E);
    chk("inv_err", {7'd0, err}, 8'h01);
    wait_an(2'b01, "inv_tens_an");
    chk("inv_tens_seg", {1'b0, seg}, 8'h06);
    count = 8'h48;
    wait_an(2'b10, "clr_units_an");
    chk("clr_err", {7'd0, err}, 8'h00);

    // Single TC pulse.
    chk("dp_idle", {7'd0, dp}, 8'h01);
    TC = 1'b1;
    @(negedge clk);
    TC = 1'b0;
    chk("dp_edge1", {7'd0, dp}, 8'h01);
    @(negedge clk);
    chk("dp_edge2", {7'd0, dp}, 8'h00);
    n = 0;
    while (dp === 1'b0 && n < 6 * R) begin
      @(negedge clk);
      n++;
    end
    chk("dp_cleared", {7'd0, dp}, 8'h01);

    // Second pulse while lit extends the flash.
    TC = 1'b1;
    @(negedge clk);
    TC = 1'b0;
    repeat (R + 2) @(negedge clk);
    TC = 1'b1;
    @(negedge clk);
    TC = 1'b0;
    n = 0;
    while (dp === 1'b0 && n < 6 * R) begin
      @(negedge clk);
      n++;
    end
    chk("dp_ext_cleared", {7'd0, dp}, 8'h01);

    // TC held high: one flash only.
    falls = 0;
    prev_dp = dp;
    TC = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (prev_dp === 1'b1 && dp === 1'b0) falls++;
      prev_dp = dp;
    end
    TC = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (prev_dp === 1'b1 && dp === 1'b0) falls++;
      prev_dp = dp;
    end
    chk("held_tc_flashes", 8'(falls), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
